// File: rtl/mux8w4b_rr_pkg.sv
// Shared widths, the output word layout and the in_data channel slicer for the 8:1 round-robin collector.
// No logic of its own.
package mux8w4b_pkg;
    localparam int CH    = 8;
    localparam int W     = 4;
    localparam int SEL_W = 3;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [W-1:0]     dat;
    } out_word_t;

    function automatic logic [W-1:0] chan_slice(input logic [CH*W-1:0] bus_dat,
                                                input logic [SEL_W-1:0] idx);
        return bus_dat[W*idx +: W];
    endfunction
endpackage

// File: rtl/mux8w4b_rr_if.sv
// Producer/consumer handshake bundle for mux8w4b_rr.
// Producers and the consumer drive the master side; the collector is the slave.
interface mux8w4b_rr_if;
    import mux8w4b_pkg::*;

    logic [CH-1:0]    in_valid;
    logic [CH*W-1:0]  in_data;
    logic [CH-1:0]    in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux8w4b_rr_arb.sv
// Combinational 8-way round-robin picker: rotate requests by ptr, take the lowest set bit, rotate back.
// Zero latency; en_i low forces no grant.
module rr_arbiter8
    import mux8w4b_pkg::*;
(
    input  logic [CH-1:0]    req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [CH-1:0]    gnt_o,
    output logic [SEL_W-1:0] gnt_idx_o,
    output logic             any_o
);
    logic [CH-1:0]    rot_req;
    logic [CH-1:0]    rot_gnt;
    logic [SEL_W-1:0] rot_idx;
    logic             found;

    always_comb begin
        rot_req = '0;
        for (int k = 0; k < CH; k++) begin
            rot_req[k] = req_i[SEL_W'(k) + ptr_i];
        end
    end

    always_comb begin
        rot_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (!found && rot_req[k]) begin
                rot_idx = SEL_W'(k);
                found   = 1'b1;
            end
        end
    end

    assign rot_gnt = found ? (CH'(1) << rot_idx) : '0;

    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < CH; k++) begin
            gnt_o[SEL_W'(k) + ptr_i] = en_i & rot_gnt[k];
        end
    end

    assign gnt_idx_o = rot_idx + ptr_i;
    assign any_o     = en_i & found;
endmodule

// File: rtl/mux8w4b_rr.sv
// Round-robin collector of eight 4-bit producers into one registered, source-tagged output.
// Latency 1 cycle; the output word holds while out_ready is low and in_ready stays zero.
module mux8w4b_rr
    import mux8w4b_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mux8w4b_rr_if.slave  bus
);
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             out_vld_q, out_vld_d;
    out_word_t        word_q, word_d;

    logic             slot_free;
    logic             arb_en;
    logic             arb_any;
    logic [CH-1:0]    arb_gnt;
    logic [SEL_W-1:0] arb_idx;

    // A full slot being drained this cycle can be refilled on the same edge.
    assign slot_free = !out_vld_q || bus.out_ready;
    assign arb_en    = slot_free && !rst;

    rr_arbiter8 u_arb (
        .req_i     (bus.in_valid),
        .ptr_i     (ptr_q),
        .en_i      (arb_en),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    always_comb begin
        ptr_d     = ptr_q;
        out_vld_d = out_vld_q;
        word_d    = word_q;
        if (arb_any) begin
            ptr_d      = arb_idx + SEL_W'(1);
            out_vld_d  = 1'b1;
            word_d.sel = arb_idx;
            word_d.dat = chan_slice(bus.in_data, arb_idx);
        end else if (slot_free) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            out_vld_q <= 1'b0;
            word_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            out_vld_q <= out_vld_d;
            word_q    <= word_d;
        end
    end

    assign bus.in_ready  = arb_gnt;
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = word_q.dat;
    assign bus.out_sel   = word_q.sel;
endmodule

// File: tb/tb_mux8w4b_rr.sv
// Directed scenarios plus a randomized run against a queue-free behavioural model of the collector.
module tb_mux8w4b_rr;
    import mux8w4b_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux8w4b_rr_if bus();

    mux8w4b_rr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int               m_ptr;
    logic             m_vld;
    logic [W-1:0]     m_data;
    logic [SEL_W-1:0] m_sel;

    function automatic int exp_grant(input logic [CH-1:0] v, input int ptr, input logic free);
        if (!free) return -1;
        for (int k = 0; k < CH; k++) begin
            if (v[(ptr + k) % CH]) return (ptr + k) % CH;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [W-1:0] v);
        bus.in_data[W*i +: W] = v;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_vld  = 1'b0;
        m_data = '0;
        m_sel  = '0;
    endtask

    // Applies the collector's rules to the inputs currently on the bus, as at a rising edge.
    task automatic model_edge();
        int   g;
        logic free;
        free = !m_vld || bus.out_ready;
        g = exp_grant(bus.in_valid, m_ptr, free);
        if (g >= 0) begin
            m_data = bus.in_data[W*g +: W];
            m_sel  = SEL_W'(g);
            m_vld  = 1'b1;
            m_ptr  = (g + 1) % CH;
        end else if (free) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 8'hFF;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #2;
        checks++;
        if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL reset_in_ready got %h want 00", bus.in_ready); end
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== 8'h00)
            begin errors++; $display("FAIL reset_outputs got v%b s%0d d%h want all zero", bus.out_valid, bus.out_sel, bus.out_data); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_edge_valid got %b want 0", bus.out_valid); end
        rst           = 1'b0;
        bus.in_valid  = 8'h10;
        set_ch(4, 4'h5);
        bus.out_ready = 1'b0;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd4, 4'h5})
            begin errors++; $display("FAIL reset_pre_word got v%b s%0d d%h want v1 s4 d5", bus.out_valid, bus.out_sel, bus.out_data); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== 8'h00)
            begin errors++; $display("FAIL reset_async got v%b s%0d d%h want all zero", bus.out_valid, bus.out_sel, bus.out_data); end
        rst           = 1'b0;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 8'h01) begin errors++; $display("FAIL reset_first_grant got %h want 01", bus.in_ready); end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_sel} !== {1'b1, 3'd0})
            begin errors++; $display("FAIL reset_first_word got v%b s%0d want v1 s0", bus.out_valid, bus.out_sel); end
    endtask

    task automatic test_rotation();
        do_reset();
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < CH; i++) set_ch(i, 4'(i + 8));
        for (int k = 0; k < 9; k++) begin
            #1;
            checks++;
            if (bus.in_ready !== (8'b1 << (k % 8)))
                begin errors++; $display("FAIL rotation_ready[%0d] got %h want %h", k, bus.in_ready, 8'b1 << (k % 8)); end
            tick();
            checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'(k % 8), 4'((k % 8) + 8)})
                begin errors++; $display("FAIL rotation_out[%0d] got v%b s%0d d%0d want v1 s%0d d%0d", k, bus.out_valid, bus.out_sel, bus.out_data, k % 8, (k % 8) + 8); end
        end
    endtask

    task automatic test_ptr_skip();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 8'h20;
        set_ch(5, 4'hA);
        set_ch(3, 4'h3);
        set_ch(6, 4'h6);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd5, 4'hA})
            begin errors++; $display("FAIL skip_ch5 got v%b s%0d d%h want v1 s5 da", bus.out_valid, bus.out_sel, bus.out_data); end
        bus.in_valid = 8'h48;
        #1;
        checks++;
        if (bus.in_ready !== 8'h40) begin errors++; $display("FAIL skip_ready6 got %h want 40", bus.in_ready); end
        tick();
        checks++;
        if ({bus.out_sel, bus.out_data} !== {3'd6, 4'h6})
            begin errors++; $display("FAIL skip_ch6 got s%0d d%h want s6 d6", bus.out_sel, bus.out_data); end
        bus.in_valid = 8'h08;
        #1;
        checks++;
        if (bus.in_ready !== 8'h08) begin errors++; $display("FAIL skip_ready3 got %h want 08", bus.in_ready); end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd3, 4'h3})
            begin errors++; $display("FAIL skip_ch3 got v%b s%0d d%h want v1 s3 d3", bus.out_valid, bus.out_sel, bus.out_data); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.in_valid  = 8'h04;
        set_ch(2, 4'h7);
        set_ch(1, 4'h9);
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 8'h02;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL bp_ready[%0d] got %h want 00", k, bus.in_ready); end
            tick();
            checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd2, 4'h7})
                begin errors++; $display("FAIL bp_hold[%0d] got v%b s%0d d%h want v1 s2 d7", k, bus.out_valid, bus.out_sel, bus.out_data); end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 8'h02) begin errors++; $display("FAIL bp_release_ready got %h want 02", bus.in_ready); end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd1, 4'h9})
            begin errors++; $display("FAIL bp_release_out got v%b s%0d d%h want v1 s1 d9", bus.out_valid, bus.out_sel, bus.out_data); end
    endtask

    task automatic test_wrap();
        logic [7:0] vld_seq [3] = '{8'h81, 8'h01, 8'h03};
        logic [7:0] rdy_seq [3] = '{8'h80, 8'h01, 8'h02};
        int         sel_seq [3] = '{7, 0, 1};
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 8'h40;
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = vld_seq[k];
            #1;
            checks++;
            if (bus.in_ready !== rdy_seq[k])
                begin errors++; $display("FAIL wrap_ready[%0d] got %h want %h", k, bus.in_ready, rdy_seq[k]); end
            tick();
            checks++;
            if ({bus.out_valid, bus.out_sel} !== {1'b1, 3'(sel_seq[k])})
                begin errors++; $display("FAIL wrap_sel[%0d] got v%b s%0d want v1 s%0d", k, bus.out_valid, bus.out_sel, sel_seq[k]); end
        end
    endtask

    task automatic test_idle_drain();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 8'h10;
        set_ch(4, 4'hC);
        tick();
        bus.in_valid = 8'h00;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL idle_ready[%0d] got %h want 00", k, bus.in_ready); end
            tick();
            checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b0, 3'd4, 4'hC})
                begin errors++; $display("FAIL idle_out[%0d] got v%b s%0d d%h want v0 s4 dc", k, bus.out_valid, bus.out_sel, bus.out_data); end
        end
    endtask

    task automatic test_random();
        int         g;
        logic [7:0] exp_rdy;
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            bus.in_valid  = 8'($urandom);
            if ($urandom_range(3) == 0) bus.in_valid = '0;
            bus.in_data   = 32'($urandom);
            bus.out_ready = ($urandom_range(9) < 7);
            #1;
            g = exp_grant(bus.in_valid, m_ptr, !m_vld || bus.out_ready);
            exp_rdy = (g >= 0) ? (8'b1 << g) : 8'h00;
            checks++;
            if (bus.in_ready !== exp_rdy)
                begin errors++; $display("FAIL rand_ready[%0d] got %h want %h", n, bus.in_ready, exp_rdy); end
            model_edge();
            tick();
            checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_data} !== {m_vld, m_sel, m_data})
                begin errors++; $display("FAIL rand_out[%0d] got v%b s%0d d%h want v%b s%0d d%h", n, bus.out_valid, bus.out_sel, bus.out_data, m_vld, m_sel, m_data); end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_ptr_skip();
        test_backpressure();
        test_wrap();
        test_idle_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
